// File: rtl/cpu_consts.sv
// Shared CPU constants: ALU function encodings and the issue-queue entry type.
package cpu_consts;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    // One fully formed ALU op, as stored in the issue queue.
    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  func;
        logic        word_op;
        logic [4:0]  rd;
    } alu_issue_t;

endpackage

// File: rtl/alu_issue_q_opr_fmt.sv
// Operand formation: a/b source select plus RV64 *W conditioning for shifts.
module alu_opr_fmt
    import cpu_consts::*;
(
    input  logic [3:0]  func_i,
    input  logic        word_op_i,
    input  logic        a_sel_i,
    input  logic        b_sel_i,
    input  logic [63:0] rs1_data_i,
    input  logic [63:0] rs2_data_i,
    input  logic [63:0] pc_i,
    input  logic [63:0] imm_i,
    output logic [63:0] opr_a_o,
    output logic [63:0] opr_b_o
);

    logic [63:0] a_raw;
    logic [63:0] b_raw;

    // Select sources, then condition word shifts so the ALU sees 32-bit semantics.
    always_comb begin
        a_raw   = a_sel_i ? pc_i  : rs1_data_i;
        b_raw   = b_sel_i ? imm_i : rs2_data_i;
        opr_a_o = a_raw;
        opr_b_o = b_raw;
        if (word_op_i) begin
            if (func_i == OP_SRL) begin
                opr_a_o = {32'h0, a_raw[31:0]};
            end else if (func_i == OP_SRA) begin
                opr_a_o = {{32{a_raw[31]}}, a_raw[31:0]};
            end
            if (func_i == OP_SLL || func_i == OP_SRL || func_i == OP_SRA) begin
                // Word shifts use only a 5-bit amount.
                opr_b_o = {59'h0, b_raw[4:0]};
            end
        end
    end

endmodule

// File: rtl/alu_issue_q.sv
// ALU issue queue: forms operands at push time and presents the FIFO head to the ALU.
module alu_issue_q
    import cpu_consts::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        dec_valid_i,
    output logic        dec_ready_o,
    input  logic [3:0]  dec_func_i,
    input  logic        dec_word_op_i,
    input  logic        dec_a_sel_i,
    input  logic        dec_b_sel_i,
    input  logic [63:0] dec_rs1_data_i,
    input  logic [63:0] dec_rs2_data_i,
    input  logic [63:0] dec_pc_i,
    input  logic [63:0] dec_imm_i,
    input  logic [4:0]  dec_rd_i,
    input  logic        ex_ready_i,
    output logic        alu_valid_o,
    output logic [63:0] opr_a_o,
    output logic [63:0] opr_b_o,
    output logic [3:0]  alu_func_o,
    output logic        word_op_o,
    output logic [4:0]  rd_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    alu_issue_t      mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic            push;
    logic            pop;
    logic [63:0]     fmt_a;
    logic [63:0]     fmt_b;
    alu_issue_t      new_entry;
    alu_issue_t      head;

    alu_opr_fmt u_opr_fmt (
        .func_i     (dec_func_i),
        .word_op_i  (dec_word_op_i),
        .a_sel_i    (dec_a_sel_i),
        .b_sel_i    (dec_b_sel_i),
        .rs1_data_i (dec_rs1_data_i),
        .rs2_data_i (dec_rs2_data_i),
        .pc_i       (dec_pc_i),
        .imm_i      (dec_imm_i),
        .opr_a_o    (fmt_a),
        .opr_b_o    (fmt_b)
    );

    // Handshake and head presentation; flush masks valid so nothing pops that cycle.
    always_comb begin
        dec_ready_o = (count_q != CntW'(DEPTH));
        alu_valid_o = (count_q != '0) & ~flush_i;
        push        = dec_valid_i & dec_ready_o & ~flush_i;
        pop         = alu_valid_o & ex_ready_i;
        new_entry   = '{a: fmt_a, b: fmt_b, func: dec_func_i, word_op: dec_word_op_i,
                        rd: dec_rd_i};
        head        = mem_q[rd_ptr_q];
        opr_a_o     = head.a;
        opr_b_o     = head.b;
        alu_func_o  = head.func;
        word_op_o   = head.word_op;
        rd_o        = head.rd;
    end

    // Next-state for pointers and occupancy; pointers wrap by power-of-two width.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

endmodule

// File: tb/tb_alu_issue_q.sv
// Self-checking bench for alu_issue_q: operand table, corner sequences, random vs queue model.
module tb_alu_issue_q;
    import cpu_consts::*;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        dec_valid_i = 1'b0;
    logic        dec_ready_o;
    logic [3:0]  dec_func_i = '0;
    logic        dec_word_op_i = 1'b0;
    logic        dec_a_sel_i = 1'b0;
    logic        dec_b_sel_i = 1'b0;
    logic [63:0] dec_rs1_data_i = '0;
    logic [63:0] dec_rs2_data_i = '0;
    logic [63:0] dec_pc_i = '0;
    logic [63:0] dec_imm_i = '0;
    logic [4:0]  dec_rd_i = '0;
    logic        ex_ready_i = 1'b0;
    logic        alu_valid_o;
    logic [63:0] opr_a_o;
    logic [63:0] opr_b_o;
    logic [3:0]  alu_func_o;
    logic        word_op_o;
    logic [4:0]  rd_o;

    alu_issue_q #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .dec_valid_i    (dec_valid_i),
        .dec_ready_o    (dec_ready_o),
        .dec_func_i     (dec_func_i),
        .dec_word_op_i  (dec_word_op_i),
        .dec_a_sel_i    (dec_a_sel_i),
        .dec_b_sel_i    (dec_b_sel_i),
        .dec_rs1_data_i (dec_rs1_data_i),
        .dec_rs2_data_i (dec_rs2_data_i),
        .dec_pc_i       (dec_pc_i),
        .dec_imm_i      (dec_imm_i),
        .dec_rd_i       (dec_rd_i),
        .ex_ready_i     (ex_ready_i),
        .alu_valid_o    (alu_valid_o),
        .opr_a_o        (opr_a_o),
        .opr_b_o        (opr_b_o),
        .alu_func_o     (alu_func_o),
        .word_op_o      (word_op_o),
        .rd_o           (rd_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: the queue contents as a plain list of expected head records.
    alu_issue_t model_q[$];

    typedef struct {
        logic [3:0]  func;
        logic        w;
        logic        asel;
        logic        bsel;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic alu_issue_t model_fmt();
        alu_issue_t  r;
        logic [63:0] a;
        logic [63:0] b;
        logic        is_shift;
        a = dec_a_sel_i ? dec_pc_i : dec_rs1_data_i;
        b = dec_b_sel_i ? dec_imm_i : dec_rs2_data_i;
        is_shift = (dec_func_i == OP_SLL) || (dec_func_i == OP_SRL) || (dec_func_i == OP_SRA);
        if (dec_word_op_i) begin
            if (dec_func_i == OP_SRL) a = a % 64'h1_0000_0000;
            if (dec_func_i == OP_SRA) a = 64'($signed(a[31:0]));
            if (is_shift) b = b % 32;
        end
        r.a = a;
        r.b = b;
        r.func = dec_func_i;
        r.word_op = dec_word_op_i;
        r.rd = dec_rd_i;
        return r;
    endfunction

    // One clock: apply controls, check outputs mid-cycle, advance the model after the edge.
    task automatic step(input logic dv, input logic exr, input logic fl);
        logic       exp_ready;
        logic       exp_valid;
        logic       push;
        logic       pop;
        alu_issue_t fmt;
        dec_valid_i = dv;
        ex_ready_i  = exr;
        flush_i     = fl;
        @(negedge clk);
        exp_ready = (model_q.size() != DEPTH);
        exp_valid = (model_q.size() != 0) && !fl;
        chk("dec_ready", 64'(dec_ready_o), 64'(exp_ready));
        chk("alu_valid", 64'(alu_valid_o), 64'(exp_valid));
        if (exp_valid) begin
            chk("head_a", opr_a_o, model_q[0].a);
            chk("head_b", opr_b_o, model_q[0].b);
            chk("head_func", 64'(alu_func_o), 64'(model_q[0].func));
            chk("head_word", 64'(word_op_o), 64'(model_q[0].word_op));
            chk("head_rd", 64'(rd_o), 64'(model_q[0].rd));
        end
        pop  = exp_valid && exr;
        push = dv && exp_ready && !fl;
        fmt  = model_fmt();
        @(posedge clk);
        #1;
        if (fl) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (push) model_q.push_back(fmt);
        end
    endtask

    task automatic set_op(input logic [3:0] f, input logic w, input logic as, input logic bs,
                          input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] pc,
                          input logic [63:0] imm, input logic [4:0] rd);
        dec_func_i = f;
        dec_word_op_i = w;
        dec_a_sel_i = as;
        dec_b_sel_i = bs;
        dec_rs1_data_i = rs1;
        dec_rs2_data_i = rs2;
        dec_pc_i = pc;
        dec_imm_i = imm;
        dec_rd_i = rd;
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * int'(DEPTH) + 2 && model_q.size() != 0; k++) step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [3:0] ops[10];
        ops = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND};

        vecs[0] = '{OP_ADD, 0, 0, 1, 64'd5, 64'h1234, 64'h0, 64'hFFFF_FFFF_FFFF_FFFD,
                    64'd5, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[1] = '{OP_SRA, 1, 0, 0, 64'h8000_0000, 64'h21, 64'h0, 64'h0,
                    64'hFFFF_FFFF_8000_0000, 64'h1};
        vecs[2] = '{OP_SRL, 1, 0, 0, 64'h8000_0000, 64'h21, 64'h0, 64'h0,
                    64'h0000_0000_8000_0000, 64'h1};
        vecs[3] = '{OP_SLL, 1, 0, 0, 64'hDEAD_BEEF_1234_5678, 64'hFF, 64'h0, 64'h0,
                    64'hDEAD_BEEF_1234_5678, 64'h1F};
        vecs[4] = '{OP_SRL, 0, 0, 0, 64'hFFFF_0000_8000_0001, 64'h7F, 64'h0, 64'h0,
                    64'hFFFF_0000_8000_0001, 64'h7F};
        vecs[5] = '{OP_ADD, 1, 0, 0, 64'h1_8000_0000, 64'hFFFF_FFFF_0000_0010, 64'h0, 64'h0,
                    64'h1_8000_0000, 64'hFFFF_FFFF_0000_0010};
        vecs[6] = '{OP_ADD, 0, 1, 1, 64'h55, 64'h66, 64'h8000_1000, 64'h1000,
                    64'h8000_1000, 64'h1000};
        vecs[7] = '{OP_SRA, 1, 0, 1, 64'h1234_5678_7FFF_FFFF, 64'h0, 64'h0, 64'h3F,
                    64'h0000_0000_7FFF_FFFF, 64'h1F};

        // Reset state.
        #2;
        chk("rst_valid", 64'(alu_valid_o), 64'h0);
        chk("rst_a", opr_a_o, 64'h0);
        chk("rst_b", opr_b_o, 64'h0);
        chk("rst_func", 64'(alu_func_o), 64'h0);
        chk("rst_word", 64'(word_op_o), 64'h0);
        chk("rst_rd", 64'(rd_o), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", 64'(dec_ready_o), 64'h1);

        // Operand formation table: push one op, check it at the head next cycle.
        for (int i = 0; i < 8; i++) begin
            set_op(vecs[i].func, vecs[i].w, vecs[i].asel, vecs[i].bsel, vecs[i].rs1,
                   vecs[i].rs2, vecs[i].pc, vecs[i].imm, 5'(i + 1));
            step(1'b1, 1'b1, 1'b0);
            chk($sformatf("vec%0d_valid", i), 64'(alu_valid_o), 64'h1);
            chk($sformatf("vec%0d_a", i), opr_a_o, vecs[i].exp_a);
            chk($sformatf("vec%0d_b", i), opr_b_o, vecs[i].exp_b);
            chk($sformatf("vec%0d_rd", i), 64'(rd_o), 64'(i + 1));
            drain();
        end

        // Fill with ex_ready low: third op refused, then in-order drain and re-push.
        set_op(OP_ADD, 0, 0, 0, 64'd10, 64'd1, 0, 0, 5'd1);
        step(1'b1, 1'b0, 1'b0);
        set_op(OP_SUB, 0, 0, 0, 64'd20, 64'd2, 0, 0, 5'd2);
        step(1'b1, 1'b0, 1'b0);
        set_op(OP_XOR, 0, 0, 0, 64'd30, 64'd3, 0, 0, 5'd3);
        step(1'b1, 1'b0, 1'b0);
        chk("full_ready", 64'(dec_ready_o), 64'h0);
        chk("full_head_rd", 64'(rd_o), 64'd1);
        step(1'b1, 1'b1, 1'b0);
        chk("pop1_rd", 64'(rd_o), 64'd2);
        chk("pop1_ready", 64'(dec_ready_o), 64'h1);
        step(1'b1, 1'b1, 1'b0);
        chk("pop2_rd", 64'(rd_o), 64'd3);
        drain();

        // Flush on a full queue with an incoming op.
        set_op(OP_OR, 0, 0, 0, 64'd1, 64'd2, 0, 0, 5'd7);
        step(1'b1, 1'b0, 1'b0);
        set_op(OP_AND, 0, 0, 0, 64'd3, 64'd4, 0, 0, 5'd8);
        step(1'b1, 1'b0, 1'b0);
        set_op(OP_ADD, 0, 0, 0, 64'd9, 64'd9, 0, 0, 5'd9);
        dec_valid_i = 1'b1;
        flush_i = 1'b1;
        #1;
        chk("flush_valid", 64'(alu_valid_o), 64'h0);
        step(1'b1, 1'b1, 1'b1);
        chk("post_flush_valid", 64'(alu_valid_o), 64'h0);
        chk("post_flush_ready", 64'(dec_ready_o), 64'h1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);

        // Back-to-back streaming at one op per cycle.
        for (int i = 0; i < 8; i++) begin
            set_op(ops[i], 1'(i), 1'(i >> 1), 1'(i >> 2), {$urandom, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 5'(i + 10));
            step(1'b1, 1'b1, 1'b0);
            chk($sformatf("stream%0d_valid", i), 64'(alu_valid_o), 64'h1);
            chk($sformatf("stream%0d_rd", i), 64'(rd_o), 64'(i + 10));
        end
        drain();

        // Asynchronous reset with two ops queued.
        set_op(OP_SUB, 1, 1, 1, 64'h1, 64'h2, 64'h3, 64'h4, 5'd21);
        step(1'b1, 1'b0, 1'b0);
        set_op(OP_SLL, 1, 0, 0, 64'h5, 64'h6, 64'h7, 64'h8, 5'd22);
        step(1'b1, 1'b0, 1'b0);
        dec_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(alu_valid_o), 64'h0);
        chk("arst_a", opr_a_o, 64'h0);
        chk("arst_b", opr_b_o, 64'h0);
        chk("arst_func", 64'(alu_func_o), 64'h0);
        chk("arst_word", 64'(word_op_o), 64'h0);
        chk("arst_rd", 64'(rd_o), 64'h0);
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_ready", 64'(dec_ready_o), 64'h1);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            set_op(ops[$urandom_range(0, 9)], 1'($urandom), 1'($urandom), 1'($urandom),
                   {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, 5'($urandom));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
